// File: rtl/id_hazard_scoreboard.sv
// Decode-stage issue controller: per-register pending-write counters drive RAW/full stalls,
// plus branch flush sequencing and a saturating stall-cycle counter.
module id_hazard_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest_addr,
    input  logic        id_writes_reg,
    input  logic        wb_register_write,
    input  logic [4:0]  wb_write_addr,
    input  logic        ex_branch_taken,
    output logic        stall,
    output logic        flush,
    output logic        issue,
    output logic [31:0] pending_mask,
    output logic [31:0] stall_count
);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    localparam logic [CNT_W-1:0] CntMax      = CNT_W'(MAX_INFLIGHT);
    localparam logic [3:0]       FlushReload = 4'(FLUSH_CYCLES - 1);
    localparam bit               MultiFlush  = (FLUSH_CYCLES > 1);

    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]            cnt_inc, cnt_dec;
    state_e                 state_q, state_d;
    logic [3:0]             flush_left_q, flush_left_d;
    logic [31:0]            stall_count_q, stall_count_d;

    logic rs_busy, rt_busy, raw, full;

    // Hazard detection reads only registered counter state.
    always_comb begin
        rs_busy = id_uses_rs && (id_rs_addr != 5'd0) && (cnt_q[id_rs_addr] != '0);
        rt_busy = id_uses_rt && (id_rt_addr != 5'd0) && (cnt_q[id_rt_addr] != '0);
        raw     = id_valid && (rs_busy || rt_busy);
        full    = id_valid && id_writes_reg && (id_dest_addr != 5'd0) &&
                  (cnt_q[id_dest_addr] == CntMax);
        stall   = (raw || full) && (state_q == StIdle) && !ex_branch_taken;
        flush   = ex_branch_taken || (state_q == StFlush);
        issue   = id_valid && !stall && !flush;
    end

    // $0 is excluded from both inc and dec, so its counter never moves.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            cnt_inc[r] = issue && id_writes_reg && (id_dest_addr == 5'(r));
            cnt_dec[r] = wb_register_write && (wb_write_addr == 5'(r)) && (cnt_q[r] != '0);
            if (cnt_inc[r] && !cnt_dec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (cnt_dec[r] && !cnt_inc[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
    end

    // A taken branch while already flushing restarts the flush window.
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        unique case (state_q)
            StIdle: begin
                if (ex_branch_taken && MultiFlush) begin
                    state_d      = StFlush;
                    flush_left_d = FlushReload;
                end
            end
            StFlush: begin
                if (ex_branch_taken) begin
                    flush_left_d = FlushReload;
                end else if (flush_left_q <= 4'd1) begin
                    state_d      = StIdle;
                    flush_left_d = 4'd0;
                end else begin
                    flush_left_d = flush_left_q - 4'd1;
                end
            end
            default: begin
                state_d      = StIdle;
                flush_left_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            state_q       <= StIdle;
            flush_left_q  <= 4'd0;
            stall_count_q <= 32'd0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            flush_left_q  <= flush_left_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed-vector bench: the driver queues hand-computed expectations per cycle and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_id_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dest_addr;
    logic        id_writes_reg;
    logic        wb_register_write;
    logic [4:0]  wb_write_addr;
    logic        ex_branch_taken;
    logic        stall;
    logic        flush;
    logic        issue;
    logic [31:0] pending_mask;
    logic [31:0] stall_count;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        issue;
        logic [31:0] mask;
        logic [31:0] scnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    id_hazard_scoreboard #(
        .MAX_INFLIGHT(3),
        .CNT_W       (2),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .id_dest_addr     (id_dest_addr),
        .id_writes_reg    (id_writes_reg),
        .wb_register_write(wb_register_write),
        .wb_write_addr    (wb_write_addr),
        .ex_branch_taken  (ex_branch_taken),
        .stall            (stall),
        .flush            (flush),
        .issue            (issue),
        .pending_mask     (pending_mask),
        .stall_count      (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
            chk({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
            chk({e.name, ".issue"}, {31'd0, issue}, {31'd0, e.issue});
            chk({e.name, ".mask"},  pending_mask,   e.mask);
            chk({e.name, ".scnt"},  stall_count,    e.scnt);
        end
    end

    task automatic vec(input logic rst, input logic v,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] dst, input logic wr,
                       input logic wbw, input logic [4:0] wba, input logic br,
                       input logic es, input logic ef, input logic ei,
                       input logic [31:0] em, input logic [31:0] esc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = rst;
        id_valid          = v;
        id_rs_addr        = rs;
        id_uses_rs        = urs;
        id_rt_addr        = rt;
        id_uses_rt        = urt;
        id_dest_addr      = dst;
        id_writes_reg     = wr;
        wb_register_write = wbw;
        wb_write_addr     = wba;
        ex_branch_taken   = br;
        e.stall = es;
        e.flush = ef;
        e.issue = ei;
        e.mask  = em;
        e.scnt  = esc;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0;
        id_rs_addr = '0;
        id_rt_addr = '0;
        id_uses_rs = 1'b0;
        id_uses_rt = 1'b0;
        id_dest_addr = '0;
        id_writes_reg = 1'b0;
        wb_register_write = 1'b0;
        wb_write_addr = '0;
        ex_branch_taken = 1'b0;
        repeat (2) @(posedge clk);

        //  rst v  rs urs rt urt dst wr wbw wba br   stall flush issue mask scnt
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   0, "rst_idle");
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 32'h0,   0, "rst_br");
        // RAW on $3: three stall cycles, issue in the cycle after the WB
        vec(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 1, 32'h0,   0, "raw_w");
        vec(0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0,  1, 0, 0, 32'h8,   0, "raw_s1");
        vec(0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0,  1, 0, 0, 32'h8,   1, "raw_s2");
        vec(0, 1, 3, 1, 0, 0, 4, 1, 1, 3, 0,  1, 0, 0, 32'h8,   2, "raw_s3");
        vec(0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0,  0, 0, 1, 32'h0,   3, "raw_iss");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  0, 0, 0, 32'h10,  3, "wb4");
        // $0 is never tracked
        vec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 32'h0,   3, "z_w");
        vec(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   3, "z_r");
        // Simultaneous inc/dec on $5, then an untracked WB to $6
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 1, 32'h0,   3, "s_w1");
        vec(0, 1, 0, 0, 0, 0, 5, 1, 1, 5, 0,  0, 0, 1, 32'h20,  3, "s_both");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 32'h20,  3, "s_chk");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 0, 0, 32'h0,   3, "s_unt");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   3, "s_nouf");
        // Counter full on $7
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 1, 32'h0,   3, "f_w1");
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 1, 32'h80,  3, "f_w2");
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 1, 32'h80,  3, "f_w3");
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h80,  3, "f_full");
        vec(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  1, 0, 0, 32'h80,  4, "f_wb");
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 1, 32'h80,  5, "f_iss");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 32'h80,  5, "f_dr1");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 32'h80,  5, "f_dr2");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 32'h80,  5, "f_dr3");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   5, "f_empty");
        // Branch flush, two cycles; flushed writer must not be counted
        vec(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 1,  0, 1, 0, 32'h0,   5, "b_pulse");
        vec(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,  0, 1, 0, 32'h0,   5, "b_fl2");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   5, "b_done");
        // Second branch during flush extends by one cycle
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 32'h0,   5, "b2_a");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 32'h0,   5, "b2_b");
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h0,   5, "b2_c");
        vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   5, "b2_d");
        // RAW via rt on $9, branch priority over stall, then reset mid-stall
        vec(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 0, 1, 32'h0,   5, "r_w");
        vec(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0,  1, 0, 0, 32'h200, 5, "r_s");
        vec(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1,  0, 1, 0, 32'h200, 6, "r_pri");
        vec(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 1, 0, 32'h200, 6, "r_fl");
        vec(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0,  1, 0, 0, 32'h200, 6, "r_s2");
        vec(1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0,  1, 0, 0, 32'h200, 7, "r_rst");
        vec(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   0, "r_after");

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
